ppu_packer: RTL and testbench
=============================

# ppu_packer

Write-side companion to the PPU. Accepts the PPU's registered int8 output stream (`valid`/`data_out`), packs four bytes per 32-bit word, buffers the words in a small FIFO, and writes them to the global buffer (GLB) at consecutive word addresses. The PPU has no backpressure, so the FIFO absorbs GLB write stalls; words lost to overflow are flagged, never silently dropped.

## Interface
- `ADDR_W`, 16, GLB word-address width
- `FIFO_DEPTH`, 4, word FIFO entries (power of two, ≥2)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_start`  in  1  one-cycle pulse; latches `base_addr` and `total_len`; ignored while `busy`
- `base_addr`  in  ADDR_W  GLB word address of the first output word
- `total_len`  in  16  number of bytes expected from the PPU
- `in_valid`  in  1  byte strobe (PPU `valid`)
- `in_data`  in  8  int8 byte (PPU `data_out`)
- `glb_we`  out  1  write request; high whenever the FIFO is non-empty
- `glb_addr`  out  ADDR_W  word address of the head word
- `glb_wdata`  out  32  head word
- `glb_wstrb`  out  4  byte enables of the head word
- `glb_ready`  in  1  GLB accepts; transfer = `glb_we && glb_ready`
- `busy`  out  1  high from the cycle after an accepted `i_start` until `done`
- `done`  out  1  one-cycle pulse when all bytes are written
- `overflow`  out  1  sticky; set when a word is pushed into a full FIFO

## Operation
- States: IDLE, PACK, DRAIN. Reset → IDLE; all outputs 0; FIFO empty; counters 0.
- IDLE: `in_valid` ignored. `i_start` with `total_len`>0 → PACK, clear `overflow`, byte counter, lane index, `glb_addr` ← `base_addr`. `i_start` with `total_len`=0 → stay IDLE, `done` pulses next cycle, `busy` never asserts.
- PACK: each `in_valid` byte goes into lane `lane_idx` (lane 0 = bits [7:0]), lane_idx increments mod 4, byte counter increments. Word pushed when lane 3 is filled or the byte is byte `total_len`-1; `wstrb` = lanes filled (e.g. 2 trailing bytes → 4'b0011). After the last byte → DRAIN. Bytes beyond `total_len` cannot arrive in PACK.
- Push into a full FIFO: word discarded, `overflow` ← 1; packing and byte counting continue. A simultaneous pop and push on a full FIFO is not overflow.
- Write side (PACK and DRAIN): head presented on `glb_*`; on a transfer the FIFO pops and `glb_addr` increments by 1, wrapping modulo 2^ADDR_W. Dropped words still advance the address (`glb_addr` tracks word index, not transfer count).
- DRAIN: `in_valid` ignored. When the FIFO becomes empty → IDLE, `done` pulses, `busy` drops in the same cycle.
- Async reset mid-operation: returns immediately to reset state; in-flight words are lost, no `done`.

## Timing
- `in_valid` byte completing a word at edge N → `glb_we`=1 in cycle N+1 (FIFO was empty).
- With `glb_ready` held high: one word per cycle, sustained throughput = 4 bytes/cycle, exceeding the PPU's 1 byte/cycle; overflow only under GLB stalls.
- Last transfer at edge M → `done`=1 in cycle M+1, `busy`=0 in cycle M+1.
- `glb_*` are stable while `glb_we && !glb_ready`.
- `i_start` and `in_valid` in the same cycle: the byte is ignored.

## Configuration
- `PPU_PACKER_BIG_ENDIAN_EN`: when defined, byte k of a word lands in bits [31-8k:24-8k] and `wstrb` fills from bit 3 downward (2 trailing bytes → 4'b1100). When undefined, little-endian as in Operation.

## Test plan
- Start base=0x0010, len=8, bytes 01..08 back-to-back, ready=1 → writes 0x04030201 @0x0010, 0x08070605 @0x0011, wstrb 4'hF; `done` one cycle after the second write.
- len=6, bytes AA..FF, ready=1 → second word 0x0000FFEE @base+1 with wstrb 4'b0011 (upper-lane data don't-care).
- len=24, ready=0 for 30 cycles, then 1 → FIFO fills at 4 words, `overflow`=1, 2 words dropped; 4 writes at base..base+3; `done` still pulses.
- base=0xFFFF, len=8 → writes at 0xFFFF then 0x0000.
- len=0 start → `done` next cycle, no `glb_we`, `busy` stays 0; second `i_start` while busy → ignored.
- Drop `rst` mid-PACK after 3 bytes → all outputs 0 immediately; fresh start len=4 writes correctly.

Source files
------------

// File: rtl/ppu_packer.sv
// ppu_packer: packs the PPU int8 byte stream into 32-bit words, buffers
// them in a small FIFO and writes them to the GLB at consecutive word
// addresses. Overflow of the FIFO is reported on a sticky flag.
// Ports: clk, rst (async active-low), i_start/base_addr/total_len (job),
// in_valid/in_data (byte stream), glb_we/glb_addr/glb_wdata/glb_wstrb/
// glb_ready (GLB write port), busy/done/overflow (status).
// Build option: define PPU_PACKER_BIG_ENDIAN_EN for big-endian lanes.
module ppu_packer #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       total_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              glb_we,
  output logic [ADDR_W-1:0] glb_addr,
  output logic [31:0]       glb_wdata,
  output logic [3:0]        glb_wstrb,
  input  logic              glb_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PACK,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       word_q, word_d;
  logic [3:0]        strb_q, strb_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     fcnt_q, fcnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  // Each entry carries its own word address so dropped words
  // still consume an address slot.
  logic [31:0]       mem_data_q [FIFO_DEPTH];
  logic [3:0]        mem_strb_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr_q [FIFO_DEPTH];

  logic        pop;
  logic        full;
  logic        byte_en;
  logic        last;
  logic        push;
  logic        wr_en;
  logic [1:0]  pos;
  logic [31:0] word_new;
  logic [3:0]  strb_new;

  assign pop     = (fcnt_q != '0) && glb_ready;
  assign full    = (fcnt_q == FULL_CNT);
  assign byte_en = (state_q == S_PACK) && in_valid;
  assign last    = (cnt_q == len_q - 16'd1);
  assign push    = byte_en && ((lane_q == 2'd3) || last);
  // A pop in the same cycle frees the slot, so that is not overflow.
  assign wr_en   = push && (!full || pop);

`ifdef PPU_PACKER_BIG_ENDIAN_EN
  assign pos = 2'd3 - lane_q;
`else
  assign pos = lane_q;
`endif

  always_comb begin
    word_new = word_q;
    strb_new = strb_q;
    word_new[{pos, 3'b000} +: 8] = in_data;
    strb_new[pos] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    word_d  = word_q;
    strb_d  = strb_q;
    waddr_d = waddr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    wptr_d  = wr_en ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    fcnt_d  = fcnt_q + CW'(wr_en) - CW'(pop);
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (total_len != 16'd0) begin
            state_d = S_PACK;
            busy_d  = 1'b1;
            ovf_d   = 1'b0;
            len_d   = total_len;
            cnt_d   = '0;
            lane_d  = '0;
            word_d  = '0;
            strb_d  = '0;
            waddr_d = base_addr;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_PACK: begin
        if (byte_en) begin
          cnt_d  = cnt_q + 16'd1;
          lane_d = lane_q + 2'd1;
          word_d = word_new;
          strb_d = strb_new;
          if (push) begin
            word_d  = '0;
            strb_d  = '0;
            waddr_d = waddr_q + 1'b1;
            if (!wr_en) ovf_d = 1'b1;
          end
          if (last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && fcnt_q == CW'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      strb_q  <= '0;
      waddr_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_strb_q[i] <= '0;
        mem_addr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      strb_q  <= strb_d;
      waddr_q <= waddr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fcnt_q  <= fcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      if (wr_en) begin
        mem_data_q[wptr_q] <= word_new;
        mem_strb_q[wptr_q] <= strb_new;
        mem_addr_q[wptr_q] <= waddr_q;
      end
    end
  end

  assign glb_we    = (fcnt_q != '0);
  assign glb_addr  = glb_we ? mem_addr_q[rptr_q] : waddr_q;
  assign glb_wdata = glb_we ? mem_data_q[rptr_q] : '0;
  assign glb_wstrb = glb_we ? mem_strb_q[rptr_q] : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ppu_packer.sv
// tb_ppu_packer: directed scoreboard bench for ppu_packer.
// Expected GLB writes are queued by the stimulus, checked by a monitor.
module tb_ppu_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [15:0] base_addr;
  logic [15:0] total_len;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        glb_we;
  logic [15:0] glb_addr;
  logic [31:0] glb_wdata;
  logic [3:0]  glb_wstrb;
  logic        glb_ready;
  logic        busy;
  logic        done;
  logic        overflow;

  ppu_packer #(.ADDR_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .base_addr(base_addr),
    .total_len(total_len),
    .in_valid(in_valid), .in_data(in_data),
    .glb_we(glb_we), .glb_addr(glb_addr),
    .glb_wdata(glb_wdata), .glb_wstrb(glb_wstrb),
    .glb_ready(glb_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_xfer = -10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Little-endian constants are converted when the big-endian build is used.
  task automatic exp_push(input logic [15:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s);
    exp_t e;
    e.a = a;
`ifdef PPU_PACKER_BIG_ENDIAN_EN
    e.d = {d[7:0], d[15:8], d[23:16], d[31:24]};
    e.s = {s[0], s[1], s[2], s[3]};
`else
    e.d = d;
    e.s = s;
`endif
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst && glb_we && glb_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                 glb_addr, glb_wdata);
      end else begin
        exp_t e;
        logic [31:0] m;
        e = exp_q.pop_front();
        m = {{8{e.s[3]}}, {8{e.s[2]}}, {8{e.s[1]}}, {8{e.s[0]}}};
        chk("wr_addr", 64'(glb_addr), 64'(e.a));
        chk("wr_data", 64'(glb_wdata & m), 64'(e.d & m));
        chk("wr_strb", 64'(glb_wstrb), 64'(e.s));
        last_xfer = cyc;
      end
    end
  end

  task automatic start(input logic [15:0] b, input logic [15:0] l);
    i_start = 1'b1;
    base_addr = b;
    total_len = l;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int max);
    int got;
    got = 0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk({nm, "_done_seen"}, 64'(got), 64'd1);
    if (got == 1) begin
      chk({nm, "_done_lat"}, 64'(cyc), 64'(last_xfer + 1));
      chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
    end
    chk({nm, "_all_written"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    i_start = 1'b0;
    base_addr = '0;
    total_len = '0;
    in_valid = 1'b0;
    in_data = '0;
    glb_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 64'(glb_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_addr", 64'(glb_addr), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Two full words, GLB always ready.
    exp_push(16'h0010, 32'h04030201, 4'hF);
    exp_push(16'h0011, 32'h08070605, 4'hF);
    start(16'h0010, 16'd8);
    chk("t1_busy", 64'(busy), 64'd1);
    for (int i = 1; i <= 8; i++) send(8'(i));
    wait_done("t1", 50);

    // Partial trailing word.
    exp_push(16'h0100, 32'hDDCCBBAA, 4'hF);
    exp_push(16'h0101, 32'h0000FFEE, 4'b0011);
    start(16'h0100, 16'd6);
    send(8'hAA); send(8'hBB); send(8'hCC);
    send(8'hDD); send(8'hEE); send(8'hFF);
    wait_done("t2", 50);

    // GLB stall long enough to overflow the FIFO.
    glb_ready = 1'b0;
    exp_push(16'h0200, 32'h03020100, 4'hF);
    exp_push(16'h0201, 32'h07060504, 4'hF);
    exp_push(16'h0202, 32'h0B0A0908, 4'hF);
    exp_push(16'h0203, 32'h0F0E0D0C, 4'hF);
    start(16'h0200, 16'd24);
    for (int i = 0; i < 24; i++) send(8'(i));
    repeat (5) @(posedge clk);
    #1;
    chk("t3_ovf", 64'(overflow), 64'd1);
    chk("t3_busy", 64'(busy), 64'd1);
    chk("t3_we", 64'(glb_we), 64'd1);
    chk("t3_stall_addr", 64'(glb_addr), 64'h0200);
    chk("t3_stall_strb", 64'(glb_wstrb), 64'(exp_q[0].s));
    chk("t3_stall_data", 64'(glb_wdata), 64'(exp_q[0].d));
    glb_ready = 1'b1;
    wait_done("t3", 50);
    chk("t3_ovf_sticky", 64'(overflow), 64'd1);

    // Address wrap; new start clears overflow.
    exp_push(16'hFFFF, 32'h44332211, 4'hF);
    exp_push(16'h0000, 32'h88776655, 4'hF);
    start(16'hFFFF, 16'd8);
    chk("t4_ovf_clr", 64'(overflow), 64'd0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    wait_done("t4", 50);

    // Zero-length job.
    start(16'h0300, 16'd0);
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_we", 64'(glb_we), 64'd0);
    @(posedge clk); #1;
    chk("t5_done_pulse", 64'(done), 64'd0);
    chk("t5_busy_after", 64'(busy), 64'd0);

    // Start while busy is ignored.
    exp_push(16'h0300, 32'h04030201, 4'hF);
    start(16'h0300, 16'd4);
    send(8'h01);
    start(16'h0500, 16'd8);
    send(8'h02); send(8'h03); send(8'h04);
    wait_done("t5b", 50);

    // Async reset mid-PACK, then a fresh job.
    start(16'h0040, 16'd8);
    send(8'h21); send(8'h22); send(8'h23);
    #2 rst = 1'b0;
    #1;
    chk("t6_we", 64'(glb_we), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);
    chk("t6_addr", 64'(glb_addr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_push(16'h0060, 32'h0C0B0A09, 4'hF);
    start(16'h0060, 16'd4);
    send(8'h09); send(8'h0A); send(8'h0B); send(8'h0C);
    wait_done("t6", 50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
